serial_rx_port: RTL and testbench

- UART-style serial receive port on the SAP-II input side, directly upstream of the WBUS input-port mux.
- Deserialises framed bytes on `serial_in` and holds the last good byte in a holding register.
- Flags `ready` to the controller. The controller consumes the byte with a one-cycle `rd` strobe, the same cycle the port drives the bus.

---
 rtl/sap2_serial_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/serial_rx_port.sv | 183 ++++++++++++++++++
 tb/tb_serial_rx_port.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap2_serial_pkg.sv
// Shared definitions for the SAP-II serial ports: receive FSM states, bit timing
// defaults and frame-length constants, which the transmit port will also use.
package sap2_serial_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DATA_BITS            = 8;
  localparam int START_BITS           = 1;
  localparam int STOP_BITS            = 1;
  localparam int FRAME_BITS_8N1       = START_BITS + DATA_BITS + STOP_BITS;
  localparam int FRAME_BITS_8E1       = FRAME_BITS_8N1 + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Even parity: the transmitted parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser that resets to 1 (idle level of a serial line).
// Shared by the serial receive port and the keyboard input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      // NOTE: non-blocking, so q takes meta's value from before this edge and
      // the chain really is two flops deep.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx_port.sv
// SAP-II serial receive port: 8N1 deserialiser (8E1 when SERIAL_RX_PARITY_EN is
// defined) feeding a one-byte holding register consumed by a one-cycle rd strobe.
module serial_rx_port
  import sap2_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 serial_in,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 ready,
  output logic                 overrun,
  output logic                 framing_err,
  output logic                 parity_err
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_e            state, state_next;
  logic                 rx_s;
  logic                 rx_prev;
  logic [1:0]           primed_sr;
  logic                 rx_fall;
  logic [CNT_W-1:0]     clk_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 cnt_restart;
  logic                 shift_en;
  logic                 frame_end;
  logic                 parity_fail;

  sync_2ff u_sync (
    .clk (CLK),
    .rst (CLR),
    .d   (serial_in),
    .q   (rx_s)
  );

  // The synchroniser's reset value is not a real line level: rx_prev only follows
  // rx_s once both flops hold sampled data, so a line held low through reset is
  // not mistaken for a start edge.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      primed_sr <= '0;
      rx_prev   <= 1'b0;
    end else begin
      primed_sr <= {primed_sr[0], 1'b1};
      rx_prev   <= primed_sr[1] ? rx_s : 1'b0;
    end
  end

  assign rx_fall = rx_prev & ~rx_s;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case statement can infer a latch.
    state_next  = state;
    cnt_restart = 1'b0;
    shift_en    = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_fall) begin
          state_next  = START;
          cnt_restart = 1'b1;
        end
      end
      START: begin
        if (clk_cnt == HALF_BIT) begin
          cnt_restart = 1'b1;
          state_next  = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == FULL_BIT) begin
          cnt_restart = 1'b1;
          shift_en    = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (clk_cnt == FULL_BIT) begin
          cnt_restart = 1'b1;
          state_next  = STOP;
        end
      end
      STOP: begin
        if (clk_cnt == FULL_BIT) begin
          frame_end  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // clk_cnt numbers the cycles of the current bit: 1 on the cycle after the start
  // edge or a sample point, so sample points fall at HALF_BIT then every FULL_BIT.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (state_next == IDLE) clk_cnt <= '0;
      else if (cnt_restart)   clk_cnt <= CNT_W'(1);
      else                    clk_cnt <= clk_cnt + 1'b1;

      if (state == START)  bit_cnt <= '0;
      else if (shift_en)   bit_cnt <= bit_cnt + 1'b1;

      if (shift_en) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  logic parity_bad_q;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)                              parity_bad_q <= 1'b0;
    else if (state == PARITY && cnt_restart) parity_bad_q <= even_parity(shift_reg) ^ rx_s;
  end

  assign parity_fail = parity_bad_q;
`else
  assign parity_fail = 1'b0;
  assign parity_err  = 1'b0;
`endif

  // A read clears first; a completing frame on the same edge then overrides, which
  // gives the swap-in-place behaviour when rd and a good frame coincide.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      data_out    <= '0;
      ready       <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      if (rd) begin
        ready       <= 1'b0;
        overrun     <= 1'b0;
        framing_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        parity_err  <= 1'b0;
`endif
      end
      if (frame_end) begin
        if (!rx_s) framing_err <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
        if (parity_fail) parity_err <= 1'b1;
`endif
        if (rx_s && !parity_fail) begin
          if (ready && !rd) begin
            overrun <= 1'b1;
          end else begin
            data_out <= shift_reg;
            ready    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_port.sv
// Randomised scoreboard bench for serial_rx_port; define SERIAL_RX_PARITY_EN to
// exercise the 8E1 build. The driver predicts each outcome, a monitor checks it.
module tb_serial_rx_port;

  localparam int CPB = 16;
`ifdef SERIAL_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Start-bit drive to ready visible: 2 synchroniser flops, half a bit to the
  // start-bit centre, (FRAME_BITS-1) whole bits to the stop-bit centre, 1 update.
  localparam int LATENCY = 2 + CPB / 2 + (FRAME_BITS - 1) * CPB + 1;

  typedef struct {
    int unsigned due;
    logic [7:0]  data;
    logic        ready;
    logic        overrun;
    logic        ferr;
    logic        perr;
    string       tag;
  } exp_t;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       serial_in;
  logic       rd;
  logic [7:0] data_out;
  logic       ready;
  logic       overrun;
  logic       framing_err;
  logic       parity_err;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;

  exp_t        sb[$];
  logic [11:0] prev_out;
  logic [11:0] last_exp;

  // Reference model of the holding register and flags.
  logic [7:0] m_data;
  logic       m_ready, m_ovr, m_ferr, m_perr;

  serial_rx_port #(.CLKS_PER_BIT(CPB)) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .serial_in   (serial_in),
    .rd          (rd),
    .data_out    (data_out),
    .ready       (ready),
    .overrun     (overrun),
    .framing_err (framing_err),
    .parity_err  (parity_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [11:0] pack_exp(input exp_t e);
    return {e.data, e.ready, e.overrun, e.ferr, e.perr};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got data=%02h rdy=%b ovr=%b ferr=%b perr=%b, want data=%02h rdy=%b ovr=%b ferr=%b perr=%b",
               name, cyc, act[11:4], act[3], act[2], act[1], act[0],
               exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Monitor: compare against the scoreboard head when it falls due, and flag any
  // output movement that no queued expectation accounts for.
  always @(negedge CLK) begin
    logic [11:0] cur;
    exp_t        e;
    if (mon_en) begin
      cur = {data_out, ready, overrun, framing_err, parity_err};
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) check({e.tag, "_missed"}, cur, pack_exp(e));
        else             check(e.tag, cur, pack_exp(e));
        last_exp <= pack_exp(e);
      end else if (cur !== prev_out) begin
        check("unexpected_change", cur, last_exp);
      end
      prev_out <= cur;
    end
  end

  task automatic push_exp(input int unsigned due, input string tag);
    exp_t e;
    e.due     = due;
    e.data    = m_data;
    e.ready   = m_ready;
    e.overrun = m_ovr;
    e.ferr    = m_ferr;
    e.perr    = m_perr;
    e.tag     = tag;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic model_read();
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Line levels in transmission order: bit 0 is the start bit.
  function automatic logic [FRAME_BITS-1:0] frame_bits(input logic [7:0] d, input logic stop_bit,
                                                       input logic par_good);
`ifdef SERIAL_RX_PARITY_EN
    logic p;
    p = par_good ? ^d : ~^d;
    return {stop_bit, p, d, 1'b0};
`else
    return {stop_bit, d, 1'b0};
`endif
  endfunction

  task automatic do_read(input string tag);
    rd = 1'b1;
    model_read();
    push_exp(cyc + 1, tag);
    idle(1);
    rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_good,
                            input logic rd_at_end, input string tag);
    logic [FRAME_BITS-1:0] bits;
    int unsigned           n0;
    bits = frame_bits(d, stop_bit, par_good);
    n0   = cyc;
    if (rd_at_end) model_read();
    if (!stop_bit) m_ferr = 1'b1;
    if (!par_good) m_perr = 1'b1;
    if (stop_bit && par_good) begin
      if (m_ready) m_ovr = 1'b1;
      else begin
        m_data  = d;
        m_ready = 1'b1;
      end
    end
    push_exp(n0 + LATENCY, tag);
    for (int c = 0; c < FRAME_BITS * CPB; c++) begin
      serial_in = bits[c / CPB];
      rd        = rd_at_end && (c == LATENCY - 1);
      idle(1);
    end
    rd        = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic send_break(input int len);
    m_ferr = 1'b1;
    push_exp(cyc + LATENCY, "break");
    serial_in = 1'b0;
    idle(len);
    serial_in = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       stop_ok, par_ok, rd_end;
    logic [FRAME_BITS-1:0] bits;

    CLR       = 1'b1;
    serial_in = 1'b1;
    rd        = 1'b0;
    model_reset();
    idle(1);
    mon_en = 1'b1;
    push_exp(cyc, "reset_state");
    idle(3);
    CLR = 1'b0;
    idle(500);
    push_exp(cyc, "idle_500");
    idle(2);

    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, "good_A5");
    idle(10);
    do_read("read_A5");
    idle(5);

    serial_in = 1'b0;
    idle(3);
    serial_in = 1'b1;
    idle(40);
    push_exp(cyc, "false_start_no_flags");
    idle(2);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, "good_3C");
    idle(10);
    do_read("read_3C");
    idle(5);

    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, "framing_5A");
    idle(10);
    do_read("read_clears_ferr");
    idle(5);

    send_frame(8'h11, 1'b1, 1'b1, 1'b0, "first_11");
    idle(10);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0, "overrun_22");
    idle(10);
    do_read("read_overrun");
    idle(5);
    send_frame(8'h11, 1'b1, 1'b1, 1'b0, "first_11_again");
    idle(10);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1, "simul_read_22");
    idle(10);

    CLR = 1'b1;
    model_reset();
    push_exp(cyc, "reset_idle_with_data");
    idle(3);
    CLR = 1'b0;
    idle(10);

    send_frame(8'h33, 1'b1, 1'b1, 1'b0, "pre_reset_33");
    idle(10);
    send_frame(8'h44, 1'b1, 1'b1, 1'b0, "pre_reset_44");
    idle(10);
    bits = frame_bits(8'h99, 1'b1, 1'b1);
    for (int c = 0; c < 5 * CPB + CPB / 2; c++) begin
      serial_in = bits[c / CPB];
      idle(1);
    end
    CLR = 1'b1;
    model_reset();
    push_exp(cyc, "reset_mid_frame");
    serial_in = 1'b0;
    idle(4);
    CLR = 1'b0;
    idle(300);
    push_exp(cyc, "low_line_after_reset");
    serial_in = 1'b1;
    idle(30);
    send_frame(8'h7E, 1'b1, 1'b1, 1'b0, "after_reset_7E");
    idle(10);
    do_read("read_7E");
    idle(5);

`ifdef SERIAL_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, "parity_bad_07");
    idle(10);
    do_read("read_clears_perr");
    idle(5);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, "parity_good_07");
    idle(10);
    do_read("read_07");
    idle(5);
`endif

    send_break(1000);
    idle(20);
    do_read("read_after_break");
    idle(5);

    for (int i = 0; i < 40; i++) begin
      d       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 7) != 0);
      par_ok  = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
      par_ok  = ($urandom_range(0, 7) != 0);
`endif
      rd_end  = stop_ok && par_ok && m_ready && ($urandom_range(0, 2) == 0);
      send_frame(d, stop_ok, par_ok, rd_end, "random_frame");
      idle($urandom_range(1, 30));
      if ($urandom_range(0, 1) == 1) begin
        do_read("random_read");
        idle(2);
      end
    end

    idle(50);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
